// File: rtl/pkt_gen_pkg.sv
// pkt_gen_pkg
// Shared definitions for the per-port packet traffic generator:
//   - width helper and default field widths
//   - header field offsets
//   - run-mode encodings
//   - FSM state constants
//   - LFSR tap constant
// Optional feature macro: PKT_GEN_LFSR_EN (LFSR payload pattern).
package pkt_gen_pkg;

    // Width of a field able to index n items.
    function automatic int field_width(input int n);
        return $clog2(n);
    endfunction

    // Defaults matching the generator's default parameters.
    localparam int WIDTH_SEL      = field_width(8);
    localparam int WIDTH_PRIORITY = field_width(8);
    localparam int WIDTH_LENGTH   = field_width(256);

    // Header word = {zero pad, length, priority, dest}, dest in the LSBs.
    function automatic int hdr_prio_offset(input int width_sel);
        return width_sel;
    endfunction

    function automatic int hdr_len_offset(input int width_sel, input int width_prio);
        return width_sel + width_prio;
    endfunction

    // Run modes; encoding 3 behaves as single.
    localparam logic [1:0] MODE_SINGLE  = 2'd0;
    localparam logic [1:0] MODE_COUNTED = 2'd1;
    localparam logic [1:0] MODE_CONT    = 2'd2;

    // FSM states.
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] PAY  = 3'd2;
    localparam logic [2:0] GAP  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    // Right-shifting Galois LFSR taps for x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/pkt_gen_payload.sv
// pkt_gen_payload
// Payload word generator. On load the pattern restarts from the packet's
// sequence number; each advance steps to the next payload word.
//   Default build     : word = {TX_PORT, seq + k}.
//   PKT_GEN_LFSR_EN   : word = Galois LFSR state seeded with {seq, 1'b1}.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   seq         sequence number of the packet being sent
//   load        header accepted: restart the pattern
//   advance     payload word accepted: step the pattern
//   word        current payload word
module pkt_gen_payload
    import pkt_gen_pkg::*;
#(
    parameter int TX_PORT    = 0,
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH_SEL  = 3,
    parameter int SEQ_WIDTH  = DATA_WIDTH - WIDTH_SEL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEQ_WIDTH-1:0]  seq,
    input  logic                  load,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] word
);

`ifdef PKT_GEN_LFSR_EN
    logic [DATA_WIDTH-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= '0;
        end else if (load) begin
            lfsr <= DATA_WIDTH'({seq, 1'b1});
        end else if (advance) begin
            lfsr <= {1'b0, lfsr[DATA_WIDTH-1:1]} ^
                    (lfsr[0] ? DATA_WIDTH'(LFSR_TAPS) : '0);
        end
    end

    assign word = lfsr;
`else
    logic [SEQ_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= seq;
        end else if (advance) begin
            count <= count + SEQ_WIDTH'(1);
        end
    end

    assign word = {WIDTH_SEL'(TX_PORT), count};
`endif

endmodule

// File: rtl/pkt_traffic_gen.sv
// pkt_traffic_gen
// Per-port packet traffic generator: emits header + payload packets on the
// wr_* bus with ready backpressure, in single, counted or continuous runs.
// Optional feature macro: PKT_GEN_LFSR_EN selects an LFSR payload pattern.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   start           level; rising edge launches a run, level keeps
//                   continuous runs alive
//   mode            0 single, 1 counted, 2 continuous, 3 single
//   pkt_count       packets per counted run
//   send_cycle      idle cycles between eop acceptance and next header
//   dest, prio      header destination and priority ("priority" is a
//                   reserved word, hence prio)
//   length          payload words (0 behaves as 1)
//   ready           downstream accept
//   wr_sop/eop/vld  framing and valid
//   wr_data         header/payload word
//   busy, done      run in progress / one-cycle completion pulse
//   pkt_sent        packets fully accepted since reset (wraps)
module pkt_traffic_gen
    import pkt_gen_pkg::*;
#(
    parameter int TX_PORT         = 0,
    parameter int PORT_NUB        = 8,
    parameter int DATA_WIDTH      = 16,
    parameter int PRIORITY        = 8,
    parameter int DATA_LENGTH_MAX = 256,
    parameter int GAP_WIDTH       = 20,
    parameter int CNT_WIDTH       = 16,
    localparam int WSEL = field_width(PORT_NUB),
    localparam int WPRI = field_width(PRIORITY),
    localparam int WLEN = field_width(DATA_LENGTH_MAX)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [CNT_WIDTH-1:0]  pkt_count,
    input  logic [GAP_WIDTH-1:0]  send_cycle,
    input  logic [WSEL-1:0]       dest,
    input  logic [WPRI-1:0]       prio,
    input  logic [WLEN-1:0]       length,
    input  logic                  ready,
    output logic                  wr_sop,
    output logic                  wr_eop,
    output logic                  wr_vld,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  pkt_sent
);

    localparam int SEQ_WIDTH = DATA_WIDTH - WSEL;

    logic [2:0]            state, next_state;
    logic                  start_q;
    logic [1:0]            mode_q;
    logic [CNT_WIDTH-1:0]  pkt_count_q;
    logic [CNT_WIDTH-1:0]  run_cnt;
    logic [CNT_WIDTH-1:0]  sent_cnt;
    logic [SEQ_WIDTH-1:0]  seq;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic [WSEL-1:0]       dest_q;
    logic [WPRI-1:0]       prio_q;
    logic [WLEN-1:0]       len_q;
    logic [WLEN:0]         idx;
    logic [WLEN:0]         last_idx;
    logic                  launch;
    logic                  last_word;
    logic                  run_end;
    logic                  hdr_enter;
    logic [DATA_WIDTH-1:0] header_word;
    logic [DATA_WIDTH-1:0] payload_word;

    assign launch    = start & ~start_q & (state == IDLE);
    // A zero length still produces one payload word.
    assign last_idx  = (len_q == '0) ? '0 : {1'b0, len_q} - (WLEN+1)'(1);
    assign last_word = (idx == last_idx);
    assign hdr_enter = (next_state == HDR) && (state != HDR);

    // Decided at eop acceptance: does this packet close the run?
    always_comb begin
        case (mode_q)
            MODE_COUNTED: run_end = (run_cnt == pkt_count_q - CNT_WIDTH'(1));
            MODE_CONT:    run_end = ~start;
            default:      run_end = 1'b1;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    next_state = (mode == MODE_COUNTED && pkt_count == '0) ? DONE : HDR;
                end
            end
            HDR: begin
                if (ready) next_state = PAY;
            end
            PAY: begin
                if (ready && last_word) begin
                    if (run_end)                 next_state = DONE;
                    else if (send_cycle == '0)   next_state = HDR;
                    else                         next_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_WIDTH'(1)) next_state = HDR;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            mode_q      <= '0;
            pkt_count_q <= '0;
            run_cnt     <= '0;
            sent_cnt    <= '0;
            seq         <= '0;
            gap_cnt     <= '0;
            dest_q      <= '0;
            prio_q      <= '0;
            len_q       <= '0;
            idx         <= '0;
        end else begin
            state   <= next_state;
            start_q <= start;
            if (launch) begin
                mode_q      <= mode;
                pkt_count_q <= pkt_count;
                run_cnt     <= '0;
            end
            if (hdr_enter) begin
                dest_q <= dest;
                prio_q <= prio;
                len_q  <= length;
            end
            if (state == HDR && ready) begin
                idx <= '0;
            end
            if (state == PAY && ready) begin
                if (last_word) begin
                    sent_cnt <= sent_cnt + CNT_WIDTH'(1);
                    seq      <= seq + SEQ_WIDTH'(1);
                    run_cnt  <= run_cnt + CNT_WIDTH'(1);
                    gap_cnt  <= send_cycle;
                end else begin
                    idx <= idx + (WLEN+1)'(1);
                end
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            end
        end
    end

    pkt_gen_payload #(
        .TX_PORT    (TX_PORT),
        .DATA_WIDTH (DATA_WIDTH),
        .WIDTH_SEL  (WSEL),
        .SEQ_WIDTH  (SEQ_WIDTH)
    ) u_payload (
        .clk     (clk),
        .rst_n   (rst_n),
        .seq     (seq),
        .load    (state == HDR && ready),
        .advance (state == PAY && ready),
        .word    (payload_word)
    );

    assign header_word = DATA_WIDTH'({len_q, prio_q, dest_q});

    // Outputs decode registered state only, so a stalled word stays stable.
    assign wr_vld   = (state == HDR) || (state == PAY);
    assign wr_sop   = (state == HDR);
    assign wr_eop   = (state == PAY) && last_word;
    assign wr_data  = (state == HDR) ? header_word :
                      (state == PAY) ? payload_word : '0;
    assign busy     = (state == HDR) || (state == PAY) || (state == GAP);
    assign done     = (state == DONE);
    assign pkt_sent = sent_cnt;

endmodule

// File: tb/tb_pkt_traffic_gen.sv
module tb_pkt_traffic_gen;

    localparam int TX_PORT = 1;
    localparam int DW      = 16;
    localparam int WS      = 3;
    localparam int WP      = 3;
    localparam int WL      = 8;
    localparam int SEQ_MOD = 1 << (DW - WS);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic [15:0]   pkt_count;
    logic [19:0]   send_cycle;
    logic [WS-1:0] dest;
    logic [WP-1:0] prio;
    logic [WL-1:0] length;
    logic          ready = 1'b1;
    logic          wr_sop, wr_eop, wr_vld, busy, done;
    logic [DW-1:0] wr_data;
    logic [15:0]   pkt_sent;

    pkt_traffic_gen #(
        .TX_PORT(TX_PORT), .PORT_NUB(8), .DATA_WIDTH(DW), .PRIORITY(8),
        .DATA_LENGTH_MAX(256), .GAP_WIDTH(20), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .pkt_count(pkt_count), .send_cycle(send_cycle), .dest(dest),
        .prio(prio), .length(length), .ready(ready),
        .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data),
        .busy(busy), .done(done), .pkt_sent(pkt_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Backpressure driver: random ready when enabled.
    bit bp_en = 1'b0;
    always @(posedge clk) begin
        #1;
        ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Bus monitor, sampled mid-cycle.
    logic [17:0] acc_q[$];
    int          gap_q[$];
    int          hdr_seen, done_cnt, hold_err, gap_len;
    bit          in_gap, prev_stall;
    logic [17:0] prev_word;

    task automatic resetMonitor();
        acc_q.delete();
        gap_q.delete();
        hdr_seen = 0; done_cnt = 0; hold_err = 0; gap_len = 0;
        in_gap = 0; prev_stall = 0; prev_word = '0;
    endtask

    always @(negedge clk) begin
        if (prev_stall && (!wr_vld || {wr_sop, wr_eop, wr_data} != prev_word)) hold_err++;
        prev_stall = wr_vld && !ready;
        prev_word  = {wr_sop, wr_eop, wr_data};
        if (wr_vld && ready) begin
            acc_q.push_back({wr_sop, wr_eop, wr_data});
            if (wr_sop) begin
                hdr_seen++;
                if (in_gap) begin
                    gap_q.push_back(gap_len);
                    in_gap = 0;
                end
            end
            if (wr_eop) begin
                in_gap  = 1;
                gap_len = 0;
            end
        end else if (!wr_vld && in_gap) begin
            gap_len++;
        end
        if (done) begin
            done_cnt++;
            in_gap = 0;
        end
    end

    // Reference model state: packets sent since reset.
    int model_sent = 0;

    function automatic logic [DW-1:0] expPayload(input int seqv, input int k);
        logic [DW-1:0] s;
`ifdef PKT_GEN_LFSR_EN
        s = DW'(((seqv % SEQ_MOD) * 2) + 1);
        for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
`else
        s = DW'((TX_PORT << (DW - WS)) + ((seqv + k) % SEQ_MOD));
`endif
        return s;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input int cnt, input int gap,
                                 input int d, input int p, input int len,
                                 input bit bp, input int cont_pkts);
        logic [17:0] exp_q[$];
        int n, leff, t;
        @(posedge clk); #1;
        mode = m; pkt_count = 16'(cnt); send_cycle = 20'(gap);
        dest = WS'(d); prio = WP'(p); length = WL'(len);
        bp_en = bp;
        resetMonitor();
        start = 1'b1;
        if (m == 2'd2) begin
            t = 0;
            while (hdr_seen < cont_pkts && t < 20000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20000) checkOutput("hdr_timeout", 0, 1);
        end
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) checkOutput("done_timeout", 0, 1);
        waitCycles(3);
        bp_en = 1'b0;

        case (m)
            2'd1:    n = cnt;
            2'd2:    n = cont_pkts;
            default: n = 1;
        endcase
        leff = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({2'b10, DW'((len << (WS + WP)) | (p << WS) | d)});
            for (int k = 0; k < leff; k++)
                exp_q.push_back({1'b0, (k == leff - 1), expPayload(model_sent + i, k)});
        end
        model_sent += n;

        checkOutput("word_count", acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            checkOutput($sformatf("word%0d", i), 32'(acc_q[i]), 32'(exp_q[i]));
        checkOutput("gap_count", gap_q.size(), (n > 0) ? n - 1 : 0);
        for (int i = 0; i < gap_q.size(); i++)
            checkOutput($sformatf("gap%0d", i), gap_q[i], gap);
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("hold_stable", hold_err, 0);
        checkOutput("busy_after", busy, 0);
        checkOutput("pkt_sent", pkt_sent, 32'(model_sent % 65536));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_vld"},  wr_vld,   0);
        checkOutput({tag, "_sop"},  wr_sop,   0);
        checkOutput({tag, "_eop"},  wr_eop,   0);
        checkOutput({tag, "_data"}, wr_data,  0);
        checkOutput({tag, "_busy"}, busy,     0);
        checkOutput({tag, "_done"}, done,     0);
        checkOutput({tag, "_sent"}, pkt_sent, 0);
    endtask

    initial begin
        int t;
        rst_n = 1'b0; start = 1'b0; mode = '0; pkt_count = '0; send_cycle = '0;
        dest = '0; prio = '0; length = '0;
        resetMonitor();
        waitCycles(3);
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        waitCycles(2);

        $display("[TB] directed runs");
        applyStimulus(2'd0, 0, 0, 2, 5, 3, 1'b0, 0);
        if (acc_q.size() > 0) checkOutput("hdr_single", 32'(acc_q[0][15:0]), 32'h00EA);
        applyStimulus(2'd1, 4, 10, 6, 1, 2, 1'b0, 0);
        applyStimulus(2'd0, 0, 0, 3, 7, 6, 1'b1, 0);
        applyStimulus(2'd2, 0, 0, 1, 2, 4, 1'b0, 3);
        applyStimulus(2'd1, 0, 3, 0, 0, 2, 1'b0, 0);
        applyStimulus(2'd0, 0, 0, 5, 3, 0, 1'b0, 0);
        applyStimulus(2'd3, 0, 0, 4, 4, 2, 1'b1, 0);

        $display("[TB] random runs");
        for (int r = 0; r < 10; r++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 4),
                          $urandom_range(0, 5), $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 6),
                          1'($urandom_range(0, 1)), $urandom_range(1, 3));
        end

        $display("[TB] reset mid-payload");
        @(posedge clk); #1;
        resetMonitor();
        mode = 2'd0; dest = 3'd1; prio = 3'd1; length = 8'd20;
        start = 1'b1;
        waitCycles(1);
        start = 1'b0;
        t = 0;
        while (acc_q.size() < 4 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) checkOutput("midpay_timeout", 0, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        waitCycles(1);
        checkIdleOutputs("midrst");
        rst_n = 1'b1;
        resetMonitor();
        waitCycles(5);
        checkOutput("midrst_no_done", done_cnt, 0);
        checkOutput("midrst_no_vld", acc_q.size(), 0);
        model_sent = 0;
        applyStimulus(2'd0, 0, 0, 7, 6, 4, 1'b0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
